// File: rtl/pipeline_debug_ctrl.sv
// Debug halt/scan sequencer: drains the pipeline, then streams x0..x(NREGS-1) over valid/ready and holds the core halted.
// Optional `DBG_PC_CAPTURE_EN` adds pc_in and a trailing PC beat (dump_idx=32).
module pipeline_debug_ctrl #(
  parameter int XLEN         = 32,
  parameter int NREGS        = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     halt_req,
  input  logic                     resume,
  output logic                     fetch_stall,
  output logic                     bubble_inject,
  output logic [$clog2(NREGS)-1:0] rf_raddr,
  input  logic [XLEN-1:0]          rf_rdata,
`ifdef DBG_PC_CAPTURE_EN
  input  logic [XLEN-1:0]          pc_in,
`endif
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [XLEN-1:0]          dump_data,
  output logic [5:0]               dump_idx,
  output logic                     dump_last,
  output logic                     halted
);

  localparam int AW = $clog2(NREGS);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [5:0] PC_IDX = 6'd32;
`ifdef DBG_PC_CAPTURE_EN
  localparam logic [5:0] LAST_IDX = 6'(NREGS);
`else
  localparam logic [5:0] LAST_IDX = 6'(NREGS - 1);
`endif

  typedef enum logic [2:0] {
    RUN,
    DRAIN,
    READ,
    SEND,
    HALTED
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] drain_cnt;
  logic [5:0]    idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    fetch_stall   = 1'b0;
    bubble_inject = 1'b0;
    dump_valid    = 1'b0;
    halted        = 1'b0;
    rf_raddr      = '0;
    case (state)
      RUN: begin
        if (halt_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        fetch_stall   = 1'b1;
        bubble_inject = 1'b1;
        if (drain_cnt == DW'(1)) state_nxt = READ;
      end
      READ: begin
        fetch_stall   = 1'b1;
        bubble_inject = 1'b1;
        rf_raddr      = idx[AW-1:0];
        state_nxt     = SEND;
      end
      SEND: begin
        fetch_stall   = 1'b1;
        bubble_inject = 1'b1;
        dump_valid    = 1'b1;
        rf_raddr      = idx[AW-1:0];
        if (dump_ready) state_nxt = dump_last ? HALTED : READ;
      end
      HALTED: begin
        fetch_stall   = 1'b1;
        bubble_inject = 1'b1;
        halted        = 1'b1;
        if (resume) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Beat registers are loaded in READ and held through SEND until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= '0;
      idx       <= '0;
      dump_data <= '0;
      dump_idx  <= '0;
      dump_last <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_req) begin
            drain_cnt <= DW'(DRAIN_CYCLES);
            idx       <= '0;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - DW'(1);
        end
        READ: begin
          dump_data <= rf_rdata;
          dump_idx  <= idx;
          dump_last <= (idx == LAST_IDX);
`ifdef DBG_PC_CAPTURE_EN
          if (idx == 6'(NREGS)) begin
            dump_data <= pc_in;
            dump_idx  <= PC_IDX;
          end
`endif
        end
        SEND: begin
          if (dump_ready) idx <= idx + 6'd1;
        end
        HALTED: begin
          if (resume) begin
            dump_data <= '0;
            dump_idx  <= '0;
            dump_last <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Randomized bench for pipeline_debug_ctrl against an expected-beat queue built from the bench's register file.
module tb_pipeline_debug_ctrl;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int DRAIN = 4;
  localparam int AW    = $clog2(NREGS);
`ifdef DBG_PC_CAPTURE_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif
  localparam int NBEATS = NREGS + (PC_EN ? 1 : 0);

  logic            clk, rst, halt_req, resume;
  logic            fetch_stall, bubble_inject, dump_valid, dump_ready, dump_last, halted;
  logic [AW-1:0]   rf_raddr;
  logic [XLEN-1:0] rf_rdata, dump_data, pc_in;
  logic [5:0]      dump_idx;
  logic [XLEN-1:0] rf [NREGS];

  typedef struct {
    logic [5:0]      idx;
    logic [XLEN-1:0] data;
    logic            last;
  } beat_t;
  beat_t q[$];

  int n_cmp = 0;
  int n_err = 0;

  assign rf_rdata = rf[rf_raddr];

  pipeline_debug_ctrl #(.XLEN(XLEN), .NREGS(NREGS), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .halt_req(halt_req), .resume(resume),
    .fetch_stall(fetch_stall), .bubble_inject(bubble_inject),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
`ifdef DBG_PC_CAPTURE_EN
    .pc_in(pc_in),
`endif
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_idx(dump_idx), .dump_last(dump_last), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {fetch_stall, bubble_inject, dump_valid, dump_last, halted, dump_idx, rf_raddr, dump_data}, 64'd0);
  endtask

  // mode: 0 ready always high, 1 random ready, 2 ready held low 10 cycles on beat 4, 3 reset mid-SEND at beat 7
  task automatic run_session(input int mode, input bit preload, input bit late_wb);
    int  k;
    int  kw;
    int  holds;
    bit  r;
    bit  prev_xfer;
    beat_t b;
    rf[0] = '0;
    for (int i = 1; i < NREGS; i++) rf[i] = $urandom;
    if (preload) begin
      rf[1] = 5; rf[2] = 10; rf[3] = 15;
      pc_in = 32'h40;
    end else begin
      pc_in = $urandom;
    end
    kw = $urandom_range(1, DRAIN);
    halt_req = 1'b0;
    repeat ($urandom_range(1, 3)) begin
      resume     = 1'($urandom % 2);
      dump_ready = 1'($urandom % 2);
      @(negedge clk);
      chk_idle("run_idle");
    end
    halt_req = 1'b1;
    resume   = 1'b0;
    @(negedge clk);
    for (k = 1; k <= DRAIN + 1; k++) begin
      chk("drain_ctl", {fetch_stall, bubble_inject, dump_valid, halted}, 4'b1100);
      if (late_wb && k == kw) rf[5] = 42;
      halt_req = 1'($urandom % 2);
      resume   = 1'($urandom % 2);
      @(negedge clk);
    end
    q.delete();
    for (int i = 0; i < NREGS; i++) begin
      b.idx = 6'(i); b.data = rf[i]; b.last = (i == NREGS - 1) && !PC_EN;
      q.push_back(b);
    end
    if (PC_EN) begin
      b.idx = 6'd32; b.data = pc_in; b.last = 1'b1;
      q.push_back(b);
    end
    prev_xfer = 1'b0;
    holds = 0;
    for (int cyc = 0; cyc < 4000 && q.size() > 0; cyc++) begin
      chk("valid_seq", dump_valid, !prev_xfer);
      if (mode == 3 && dump_valid && q[0].idx == 7) begin
        dump_ready = 1'b0;
        halt_req   = 1'b0;
        resume     = 1'b0;
        @(negedge clk);
        chk("abort_hold", {dump_valid, dump_idx}, {1'b1, 6'd7});
        #2 rst = 1'b1;
        #1 chk_idle("rst_async");
        @(negedge clk);
        chk_idle("rst_hold");
        rst = 1'b0;
        return;
      end
      case (mode)
        0:       r = 1'b1;
        2:       r = !(q[0].idx == 7'd4 && holds < 10);
        default: r = ($urandom % 3) != 0;
      endcase
      if (dump_valid) begin
        chk("beat_idx", dump_idx, q[0].idx);
        chk("beat_data", dump_data, q[0].data);
        chk("beat_last", dump_last, q[0].last);
        chk("send_ctl", {fetch_stall, bubble_inject, halted}, 3'b110);
        if (q[0].idx != 6'd32) chk("raddr", rf_raddr, q[0].idx[AW-1:0]);
        if (mode == 2 && q[0].idx == 6'd4 && !r) holds++;
      end
      dump_ready = r;
      prev_xfer  = dump_valid && r;
      if (prev_xfer) void'(q.pop_front());
      halt_req = 1'($urandom % 2);
      resume   = 1'($urandom % 2);
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      chk("scan_timeout", q.size(), 0);
      return;
    end
    if (mode == 2) chk("bp_holds", holds, 10);
    chk("halted_ctl", {fetch_stall, bubble_inject, dump_valid, halted}, 4'b1101);
    if (mode == 0) chk("scan_len", k, DRAIN + 2 * NBEATS + 1);
    repeat ($urandom_range(1, 4)) begin
      halt_req = 1'($urandom % 2);
      resume   = 1'b0;
      @(negedge clk);
      chk("halt_hold", {fetch_stall, bubble_inject, dump_valid, halted}, 4'b1101);
    end
    resume   = 1'b1;
    halt_req = 1'b0;
    @(negedge clk);
    resume = 1'b0;
    chk_idle("resumed");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; halt_req = 1'b0; resume = 1'b0; dump_ready = 1'b0; pc_in = '0;
    for (int i = 0; i < NREGS; i++) rf[i] = '0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    run_session(0, 1'b1, 1'b1);
    run_session(2, 1'b0, 1'b0);
    run_session(1, 1'b0, 1'b1);
    run_session(3, 1'b0, 1'b0);
    run_session(1, 1'b1, 1'b0);
    run_session(0, 1'b0, 1'b0);
    run_session(1, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
